// File: rtl/mc_sync_fifo.sv
// Multi-channel single-clock FIFO: NUM_CH independent queues sharing one push and one pop port.
// Define MC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module mc_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int NUM_CH   = 4,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W   = $clog2(DEPTH) + 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] empty,
    output logic [NUM_CH-1:0] almost_full,
    output logic [NUM_CH-1:0] almost_empty,
    output logic [CNT_W-1:0]  level,
    output logic [NUM_CH-1:0] overflow,
    output logic [NUM_CH-1:0] underflow,
    input  logic              err_clr
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  fill     [NUM_CH];
    logic [DATA_W-1:0] head_w   [NUM_CH];

    logic [NUM_CH-1:0] wr_sel, rd_sel, push_acc, pop_acc;
    logic [NUM_CH-1:0] full_w, empty_w;
    logic [NUM_CH-1:0] ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_W-1:0] head_sel;
    logic [CNT_W-1:0]  level_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] mem_q [DEPTH];

            // Out-of-range channel indices never decode, so such requests are dropped silently.
            assign wr_sel[gi]   = push && (wr_ch == CH_W'(gi));
            assign rd_sel[gi]   = pop  && (rd_ch == CH_W'(gi));

            assign fill[gi]     = wr_ptr_q[gi] - rd_ptr_q[gi];
            assign empty_w[gi]  = (wr_ptr_q[gi] == rd_ptr_q[gi]);
            assign full_w[gi]   = (wr_ptr_q[gi][IDX_W-1:0] == rd_ptr_q[gi][IDX_W-1:0]) &&
                                  (wr_ptr_q[gi][IDX_W] != rd_ptr_q[gi][IDX_W]);
            assign almost_full[gi]  = (fill[gi] >= PTR_W'(AF_LEVEL));
            assign almost_empty[gi] = (fill[gi] <= PTR_W'(AE_LEVEL));

            // Acceptance uses pre-edge flags: no pop-makes-room, no write-to-read bypass.
            assign push_acc[gi] = wr_sel[gi] & ~full_w[gi];
            assign pop_acc[gi]  = rd_sel[gi] & ~empty_w[gi];

            assign wr_ptr_d[gi] = wr_ptr_q[gi] + PTR_W'(push_acc[gi]);
            assign rd_ptr_d[gi] = rd_ptr_q[gi] + PTR_W'(pop_acc[gi]);

            assign ovf_d[gi] = (wr_sel[gi] & full_w[gi])  | (ovf_q[gi] & ~err_clr);
            assign unf_d[gi] = (rd_sel[gi] & empty_w[gi]) | (unf_q[gi] & ~err_clr);

            always_ff @(posedge clk) begin
                if (push_acc[gi]) begin
                    mem_q[wr_ptr_q[gi][IDX_W-1:0]] <= data_in;
                end
            end

            assign head_w[gi] = mem_q[rd_ptr_q[gi][IDX_W-1:0]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_comb begin
        head_sel  = '0;
        level_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                head_sel  = head_w[i];
                level_sel = CNT_W'(fill[i]);
            end
        end
    end

`ifdef MC_FIFO_FWFT_EN
    logic rd_avail;

    always_comb begin
        rd_avail = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_avail = ~empty_w[i];
            end
        end
    end

    assign data_out   = head_sel;
    assign data_valid = rd_avail;
`else
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;

    // Only the rd_ch channel can accept a pop, so head_sel is the word being popped.
    always_comb begin
        data_valid_d = |pop_acc;
        data_out_d   = data_valid_d ? head_sel : data_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`endif

    assign full      = full_w;
    assign empty     = empty_w;
    assign level     = level_sel;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/mc_sync_fifo.md
Name: mc_sync_fifo

Overview:
- Multi-channel single-clock FIFO: NUM_CH independent queues, each DEPTH words of DATA_W bits, sharing one push port and one pop port, each with a channel select.
- Parametrised successor to the team's single-queue FIFO top. Used where several logical streams share one clock domain, e.g. per-channel buffering after the async FIFO crossing.
- Adds per-channel almost-full/almost-empty flags, fill level, sticky overflow/underflow flags and an optional first-word-fall-through mode.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, words per channel; power of two, >=2
NUM_CH, 4, number of independent channels (>=1)
AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)
Derived widths:
- CH_W = max(1, $clog2(NUM_CH))
- PTR_W = $clog2(DEPTH)+1, with the MSB used as the wrap bit
- CNT_W = $clog2(DEPTH+1)

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset; deasserts synchronously to clk at system level
push  in  1  write request
wr_ch  in  CH_W  channel targeted by push
data_in  in  DATA_W  write data
pop  in  1  read request
rd_ch  in  CH_W  channel targeted by pop; also selects level and data_out source
data_out  out  DATA_W  read data
data_valid  out  1  data_out holds a word popped in the previous cycle (standard mode)
full  out  NUM_CH  per-channel full
empty  out  NUM_CH  per-channel empty
almost_full  out  NUM_CH  per-channel level >= AF_LEVEL
almost_empty  out  NUM_CH  per-channel level <= AE_LEVEL
level  out  CNT_W  fill count of channel rd_ch (combinational from rd_ch)
overflow  out  NUM_CH  sticky: a push was rejected because the channel was full
underflow  out  NUM_CH  sticky: a pop was rejected because the channel was empty
err_clr  in  1  clears overflow and underflow; set-on-error has priority in the same cycle

Behaviour:
- Reset (rst low, asynchronous):
  - all pointers = 0; data_out = 0; data_valid = 0
  - full = 0, empty = all 1s, almost_full = 0, almost_empty = all 1s (AE_LEVEL >= 0)
  - overflow = 0, underflow = 0
  - storage contents are not reset
  - reset mid-operation discards all queued words; an in-flight pop produces no data_valid
- Per channel:
  - wr_ptr and rd_ptr are PTR_W bits wide; level = wr_ptr - rd_ptr, modulo 2^PTR_W
  - empty when the pointers are equal
  - full when the low bits are equal and the MSBs differ
  - pointers wrap naturally from DEPTH-1 back to 0 and toggle the MSB
- Flags are registered-state derived: full, empty, almost_* and level reflect the pointers after the last edge; there is no look-ahead.
- Push: accepted iff push=1 and full[wr_ch]=0, using full as it stands before this edge.
  - Accepted: the word is written at wr_ptr[wr_ch] and the pointer increments.
  - Rejected: no state change; overflow[wr_ch] is set.
- Pop (standard mode): accepted iff pop=1 and empty[rd_ch]=0.
  - The head word is registered into data_out and data_valid=1 on the next cycle, so latency is 1 cycle.
  - Without an accepted pop, data_valid=0 and data_out holds its last value.
  - Rejected: underflow[rd_ch] is set.
- Simultaneous push and pop, same channel:
  - Full is evaluated before the pop, so the push is rejected (overflow set) while the pop proceeds.
  - Empty is evaluated before the push, so the pop is rejected (underflow set) while the push is accepted. A write is never bypassed to the read port.
  - Otherwise both proceed and level is unchanged.
- Different channels: push and pop are fully independent in the same cycle.
- Out-of-range channel index (>= NUM_CH): the request is ignored and no flag is set.

Optional Feature:
MC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - data_out is combinationally the head word of rd_ch; data_valid = ~empty[rd_ch]
  - pop acknowledges that word and advances rd_ptr; it has zero-cycle read latency
  - data_out is undefined when data_valid=0
- Undefined: standard registered read as described in Behaviour.
- All flags and the push/pop acceptance rules are identical in both modes.

Test Plan (DATA_W=16, DEPTH=8, NUM_CH=4, AF_LEVEL=6, AE_LEVEL=1):
- Reset, then idle -> empty=4'b1111, full=0, level=0, data_valid=0, data_out=0.
- Push 0x0001..0x0008 to ch2, then pop 8x from ch2 -> full[2]=1 after the 8th push; almost_full[2]=1 from level 6; data_out sequence 0x0001..0x0008, each 1 cycle after its pop; empty[2]=1 at the end.
- Ch2 full, push 0xDEAD with a simultaneous pop on ch2 -> push rejected, overflow[2]=1, level 7; the popped word is 0x0001. Assert err_clr -> overflow[2]=0.
- Empty ch0, push 0x00AA and pop ch0 in the same cycle -> underflow[0]=1, data_valid=0, level=1. Next pop returns 0x00AA.
- Interleave: push ch1 0x1111 while popping ch3, which holds 0x3333 -> both succeed; data_out=0x3333 next cycle; level(ch1)=1.
- 20 push/pop cycles on ch0 to force pointer wrap -> data order preserved, no flag errors. Assert rst mid-stream -> all channels empty, no data_valid.
